// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two memory requesters (dsp, host), the shared
// single-port scratch memory and the arbiter that sits between them.
//   dsp_*  : dsp access request, grant and read-return channel
//   host_* : host/config access request, grant and read-return channel
//   mem_*  : memory chip-select, write-enable, address, write/read data
//   busy   : arbiter currently owned by a requester
// Modports:
//   slave  : the arbiter side
//   master : the environment side (requesters plus memory)
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 14
);
  logic          dsp_req;
  logic          dsp_we;
  logic [AW-1:0] dsp_addr;
  logic [DW-1:0] dsp_wdata;
  logic          dsp_gnt;
  logic          dsp_rvalid;
  logic [DW-1:0] dsp_rdata;

  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;

  logic          mem_cs;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;

  modport slave (
    input  dsp_req, dsp_we, dsp_addr, dsp_wdata,
    input  host_req, host_we, host_addr, host_wdata,
    input  mem_rdata,
    output dsp_gnt, dsp_rvalid, dsp_rdata,
    output host_gnt, host_rvalid, host_rdata,
    output mem_cs, mem_we, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output dsp_req, dsp_we, dsp_addr, dsp_wdata,
    output host_req, host_we, host_addr, host_wdata,
    output mem_rdata,
    input  dsp_gnt, dsp_rvalid, dsp_rdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_cs, mem_we, mem_addr, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port scratch memory between the dsp
// memory port and the host/config port. One access is issued per cycle; an
// owner keeps the port for at most BURST_MAX grants while the other side
// waits. Read data is steered back to the issuing requester through a tag
// pipeline that matches the memory read latency.
// Ports:
//   clk  : clock, all state on the rising edge
//   rstn : asynchronous reset, active-high (1 = reset asserted)
//   bus  : mem_port_arbiter_if.slave (requester, memory and busy signals)
module mem_port_arbiter #(
  parameter int unsigned AW        = 6,
  parameter int unsigned DW        = 14,
  parameter int unsigned RD_LAT    = 1,  // 1..4
  parameter int unsigned BURST_MAX = 4   // 1..15
) (
  input logic               clk,
  input logic               rstn,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StOwnDsp  = 2'd1,
    StOwnHost = 2'd2
  } owner_e;

  owner_e            owner_q;
  logic              rr_q;      // 0: dsp preferred, 1: host preferred
  logic [3:0]        bcnt_q;
  logic [4:0]        bcnt_inc;  // one bit wider so BURST_MAX = 15 cannot wrap
  logic              dsp_gnt;
  logic              host_gnt;
  logic              cur_req;
  logic              oth_req;
  owner_e            oth_owner;
  logic              rd_push;
  logic [RD_LAT-1:0] tag_vld_q;
  logic [RD_LAT-1:0] tag_host_q;

  assign dsp_gnt  = (owner_q == StOwnDsp) && bus.dsp_req;
  assign host_gnt = (owner_q == StOwnHost) && bus.host_req;

  assign bus.dsp_gnt  = dsp_gnt;
  assign bus.host_gnt = host_gnt;
  assign bus.busy     = (owner_q != StIdle);

  always_comb begin
    bus.mem_cs    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (dsp_gnt) begin
      bus.mem_cs    = 1'b1;
      bus.mem_we    = bus.dsp_we;
      bus.mem_addr  = bus.dsp_addr;
      bus.mem_wdata = bus.dsp_wdata;
    end else if (host_gnt) begin
      bus.mem_cs    = 1'b1;
      bus.mem_we    = bus.host_we;
      bus.mem_addr  = bus.host_addr;
      bus.mem_wdata = bus.host_wdata;
    end
  end

  // Current owner's request vs. the waiting side, so both owner states share one rule set.
  assign cur_req   = (owner_q == StOwnHost) ? bus.host_req : bus.dsp_req;
  assign oth_req   = (owner_q == StOwnHost) ? bus.dsp_req : bus.host_req;
  assign oth_owner = (owner_q == StOwnHost) ? StOwnDsp : StOwnHost;
  assign bcnt_inc  = {1'b0, bcnt_q} + 5'd1;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      owner_q <= StIdle;
      rr_q    <= 1'b0;
      bcnt_q  <= '0;
    end else begin
      unique case (owner_q)
        StIdle: begin
          bcnt_q <= '0;
          if (bus.dsp_req && (!bus.host_req || !rr_q)) begin
            owner_q <= StOwnDsp;
          end else if (bus.host_req) begin
            owner_q <= StOwnHost;
          end
        end
        StOwnDsp, StOwnHost: begin
          if (cur_req && !oth_req) begin
            // Uncontended: keep counting but saturate.
            bcnt_q <= (bcnt_inc >= 5'(BURST_MAX)) ? 4'(BURST_MAX) : bcnt_inc[3:0];
          end else if (cur_req && (bcnt_inc < 5'(BURST_MAX))) begin
            bcnt_q <= bcnt_inc[3:0];
          end else begin
            // Last grant of the burst, owner released, or nobody left: hand over.
            owner_q <= oth_req ? oth_owner : StIdle;
            bcnt_q  <= '0;
            rr_q    <= (owner_q == StOwnDsp);
          end
        end
        default: begin
          owner_q <= StIdle;
          bcnt_q  <= '0;
        end
      endcase
    end
  end

  // Each issued read pushes {valid, is_host}; writes push an invalid tag.
  assign rd_push = (dsp_gnt && !bus.dsp_we) || (host_gnt && !bus.host_we);

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      tag_vld_q  <= '0;
      tag_host_q <= '0;
    end else begin
      tag_vld_q[0]  <= rd_push;
      tag_host_q[0] <= host_gnt;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld_q[i]  <= tag_vld_q[i-1];
        tag_host_q[i] <= tag_host_q[i-1];
      end
    end
  end

  assign bus.dsp_rvalid  = tag_vld_q[RD_LAT-1] && !tag_host_q[RD_LAT-1];
  assign bus.host_rvalid = tag_vld_q[RD_LAT-1] && tag_host_q[RD_LAT-1];
  assign bus.dsp_rdata   = bus.mem_rdata;
  assign bus.host_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Two instances share clock and reset:
//   u_dut1 : RD_LAT=1, BURST_MAX=4 (write/read, burst, owner-drop, round-robin)
//   u_dut3 : RD_LAT=3, BURST_MAX=1 (interleaved reads, reset mid-burst)
// Each instance has a small behavioural memory with the matching read latency.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nchecks = 0;
  int   nerrors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(6), .DW(14)) b1 ();
  mem_port_arbiter_if #(.AW(6), .DW(14)) b3 ();

  mem_port_arbiter #(.AW(6), .DW(14), .RD_LAT(1), .BURST_MAX(4)) u_dut1 (
    .clk  (clk),
    .rstn (rst),
    .bus  (b1)
  );

  mem_port_arbiter #(.AW(6), .DW(14), .RD_LAT(3), .BURST_MAX(1)) u_dut3 (
    .clk  (clk),
    .rstn (rst),
    .bus  (b3)
  );

  // Memory models: write at the edge, read data RD_LAT cycles after the cs cycle.
  logic [13:0] mem1 [64];
  logic [13:0] mem3 [64];
  logic [13:0] rd1;
  logic [13:0] p3_0, p3_1, p3_2;

  always @(posedge clk) begin
    if (b1.mem_cs && b1.mem_we) mem1[b1.mem_addr] <= b1.mem_wdata;
    rd1 <= mem1[b1.mem_addr];
    if (b3.mem_cs && b3.mem_we) mem3[b3.mem_addr] <= b3.mem_wdata;
    p3_0 <= mem3[b3.mem_addr];
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end

  assign b1.mem_rdata = rd1;
  assign b3.mem_rdata = p3_2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    b1.dsp_req = 1'b0;  b1.dsp_we = 1'b0;  b1.dsp_addr = '0;  b1.dsp_wdata = '0;
    b1.host_req = 1'b0; b1.host_we = 1'b0; b1.host_addr = '0; b1.host_wdata = '0;
    b3.dsp_req = 1'b0;  b3.dsp_we = 1'b0;  b3.dsp_addr = '0;  b3.dsp_wdata = '0;
    b3.host_req = 1'b0; b3.host_we = 1'b0; b3.host_addr = '0; b3.host_wdata = '0;
  endtask

  task automatic test_reset();
    logic [6:0]  ctl;
    logic [19:0] bus_v;
    repeat (2) tick();
    smp();
    ctl = {b1.dsp_gnt, b1.host_gnt, b1.dsp_rvalid, b1.host_rvalid, b1.mem_cs, b1.mem_we, b1.busy};
    nchecks++;
    if (ctl !== 7'b0) begin
      nerrors++; $display("FAIL reset_b1_ctl: got %b want %b", ctl, 7'b0);
    end
    bus_v = {b1.mem_addr, b1.mem_wdata};
    nchecks++;
    if (bus_v !== 20'h0) begin
      nerrors++; $display("FAIL reset_b1_bus: got %h want %h", bus_v, 20'h0);
    end
    ctl = {b3.dsp_gnt, b3.host_gnt, b3.dsp_rvalid, b3.host_rvalid, b3.mem_cs, b3.mem_we, b3.busy};
    nchecks++;
    if (ctl !== 7'b0) begin
      nerrors++; $display("FAIL reset_b3_ctl: got %b want %b", ctl, 7'b0);
    end
    tick();
    rst = 1'b0;
    smp();
    nchecks++;
    if ({b1.busy, b1.mem_cs} !== 2'b00) begin
      nerrors++; $display("FAIL idle_after_reset: got %b want %b", {b1.busy, b1.mem_cs}, 2'b00);
    end
  endtask

  task automatic test_dsp_write();
    logic [4:0] ctl;
    tick();
    b1.dsp_req = 1'b1; b1.dsp_we = 1'b1; b1.dsp_addr = 6'h05; b1.dsp_wdata = 14'h2A5B;
    smp();
    nchecks++;
    if ({b1.dsp_gnt, b1.busy} !== 2'b00) begin
      nerrors++; $display("FAIL wr_t0: got %b want %b", {b1.dsp_gnt, b1.busy}, 2'b00);
    end
    tick();
    smp();
    ctl = {b1.dsp_gnt, b1.host_gnt, b1.mem_cs, b1.mem_we, b1.busy};
    nchecks++;
    if (ctl !== 5'b10111) begin
      nerrors++; $display("FAIL wr_gnt: got %b want %b", ctl, 5'b10111);
    end
    nchecks++;
    if ({b1.mem_addr, b1.mem_wdata} !== {6'h05, 14'h2A5B}) begin
      nerrors++;
      $display("FAIL wr_bus: got %h/%h want 05/2a5b", b1.mem_addr, b1.mem_wdata);
    end
    tick();
    b1.dsp_req = 1'b0; b1.dsp_we = 1'b0;
    smp();
    nchecks++;
    if ({b1.dsp_gnt, b1.mem_cs, b1.busy} !== 3'b001) begin
      nerrors++;
      $display("FAIL wr_drop: got %b want %b", {b1.dsp_gnt, b1.mem_cs, b1.busy}, 3'b001);
    end
    tick();
    smp();
    nchecks++;
    if (b1.busy !== 1'b0) begin
      nerrors++; $display("FAIL wr_idle_busy: got %b want %b", b1.busy, 1'b0);
    end
  endtask

  task automatic test_host_read();
    tick();
    b1.host_req = 1'b1; b1.host_we = 1'b0; b1.host_addr = 6'h05;
    smp();
    nchecks++;
    if (b1.host_gnt !== 1'b0) begin
      nerrors++; $display("FAIL rd_t0: got %b want %b", b1.host_gnt, 1'b0);
    end
    tick();
    smp();
    nchecks++;
    if ({b1.host_gnt, b1.dsp_gnt, b1.mem_cs, b1.mem_we, b1.mem_addr, b1.host_rvalid}
        !== {4'b1010, 6'h05, 1'b0}) begin
      nerrors++;
      $display("FAIL rd_gnt: got gnt=%b cs=%b we=%b addr=%h rv=%b want 1 1 0 05 0",
               b1.host_gnt, b1.mem_cs, b1.mem_we, b1.mem_addr, b1.host_rvalid);
    end
    tick();
    b1.host_req = 1'b0;
    smp();
    nchecks++;
    if ({b1.host_rvalid, b1.dsp_rvalid} !== 2'b10) begin
      nerrors++;
      $display("FAIL rd_rvalid: got %b want %b", {b1.host_rvalid, b1.dsp_rvalid}, 2'b10);
    end
    nchecks++;
    if (b1.host_rdata !== 14'h2A5B) begin
      nerrors++; $display("FAIL rd_rdata: got %h want %h", b1.host_rdata, 14'h2A5B);
    end
    tick();
    smp();
    nchecks++;
    if ({b1.host_rvalid, b1.dsp_rvalid, b1.busy} !== 3'b000) begin
      nerrors++;
      $display("FAIL rd_after: got %b want %b", {b1.host_rvalid, b1.dsp_rvalid, b1.busy}, 3'b000);
    end
  endtask

  task automatic test_burst();
    logic [1:0] exp_seq [12];
    logic [5:0] exp_addr;
    exp_seq = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01,
                2'b10, 2'b10, 2'b10, 2'b10};
    tick();
    b1.dsp_req = 1'b1;  b1.dsp_we = 1'b1;  b1.dsp_addr = 6'h10;  b1.dsp_wdata = 14'h0111;
    b1.host_req = 1'b1; b1.host_we = 1'b1; b1.host_addr = 6'h11; b1.host_wdata = 14'h0222;
    smp();
    nchecks++;
    if ({b1.dsp_gnt, b1.host_gnt} !== 2'b00) begin
      nerrors++; $display("FAIL burst_t0: got %b want %b", {b1.dsp_gnt, b1.host_gnt}, 2'b00);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      smp();
      nchecks++;
      if ({b1.dsp_gnt, b1.host_gnt} !== exp_seq[i]) begin
        nerrors++;
        $display("FAIL burst_gnt[%0d]: got %b want %b", i, {b1.dsp_gnt, b1.host_gnt}, exp_seq[i]);
      end
      exp_addr = exp_seq[i][1] ? 6'h10 : 6'h11;
      nchecks++;
      if ({b1.mem_cs, b1.mem_addr} !== {1'b1, exp_addr}) begin
        nerrors++;
        $display("FAIL burst_bus[%0d]: got cs=%b addr=%h want 1 %h", i, b1.mem_cs, b1.mem_addr,
                 exp_addr);
      end
    end
    // Twelfth grant ended dsp's burst, so host now owns with no request left.
    tick();
    b1.dsp_req = 1'b0; b1.host_req = 1'b0;
    smp();
    nchecks++;
    if ({b1.dsp_gnt, b1.host_gnt, b1.busy} !== 3'b001) begin
      nerrors++;
      $display("FAIL burst_end: got %b want %b", {b1.dsp_gnt, b1.host_gnt, b1.busy}, 3'b001);
    end
    tick();
    smp();
    nchecks++;
    if (b1.busy !== 1'b0) begin
      nerrors++; $display("FAIL burst_idle: got %b want %b", b1.busy, 1'b0);
    end
  endtask

  task automatic test_owner_drop();
    tick();
    b1.dsp_req = 1'b1; b1.dsp_we = 1'b1; b1.dsp_addr = 6'h20; b1.dsp_wdata = 14'h0333;
    tick();
    b1.host_req = 1'b1; b1.host_we = 1'b1; b1.host_addr = 6'h21; b1.host_wdata = 14'h0444;
    smp();
    nchecks++;
    if ({b1.dsp_gnt, b1.host_gnt} !== 2'b10) begin
      nerrors++; $display("FAIL drop_first: got %b want %b", {b1.dsp_gnt, b1.host_gnt}, 2'b10);
    end
    tick();
    b1.dsp_req = 1'b0;
    smp();
    nchecks++;
    if ({b1.dsp_gnt, b1.host_gnt, b1.mem_cs, b1.busy} !== 4'b0001) begin
      nerrors++;
      $display("FAIL drop_gap: got %b want %b", {b1.dsp_gnt, b1.host_gnt, b1.mem_cs, b1.busy},
               4'b0001);
    end
    tick();
    smp();
    nchecks++;
    if ({b1.dsp_gnt, b1.host_gnt, b1.mem_addr, b1.mem_wdata} !== {2'b01, 6'h21, 14'h0444}) begin
      nerrors++;
      $display("FAIL drop_host: got gnt=%b%b addr=%h wd=%h want 01 21 0444", b1.dsp_gnt,
               b1.host_gnt, b1.mem_addr, b1.mem_wdata);
    end
    tick();
    b1.host_req = 1'b0;
    tick();
    // Host released last, so dsp is preferred on a simultaneous request.
    b1.dsp_req = 1'b1; b1.host_req = 1'b1;
    smp();
    nchecks++;
    if ({b1.dsp_gnt, b1.host_gnt, b1.busy} !== 3'b000) begin
      nerrors++;
      $display("FAIL rr_idle0: got %b want %b", {b1.dsp_gnt, b1.host_gnt, b1.busy}, 3'b000);
    end
    tick();
    smp();
    nchecks++;
    if ({b1.dsp_gnt, b1.host_gnt} !== 2'b10) begin
      nerrors++; $display("FAIL rr_dsp_pref: got %b want %b", {b1.dsp_gnt, b1.host_gnt}, 2'b10);
    end
    tick();
    b1.dsp_req = 1'b0; b1.host_req = 1'b0;
    tick();
    // Dsp released last, so host is preferred now.
    b1.dsp_req = 1'b1; b1.host_req = 1'b1;
    tick();
    smp();
    nchecks++;
    if ({b1.dsp_gnt, b1.host_gnt} !== 2'b01) begin
      nerrors++; $display("FAIL rr_host_pref: got %b want %b", {b1.dsp_gnt, b1.host_gnt}, 2'b01);
    end
    tick();
    b1.dsp_req = 1'b0; b1.host_req = 1'b0;
    tick();
  endtask

  task automatic test_interleaved();
    tick();
    b3.host_req = 1'b1; b3.host_we = 1'b1; b3.host_addr = 6'h07; b3.host_wdata = 14'h1111;
    tick();
    smp();
    nchecks++;
    if ({b3.host_gnt, b3.mem_addr} !== {1'b1, 6'h07}) begin
      nerrors++; $display("FAIL il_wr0: got gnt=%b addr=%h want 1 07", b3.host_gnt, b3.mem_addr);
    end
    tick();
    b3.host_addr = 6'h09; b3.host_wdata = 14'h2222;
    smp();
    nchecks++;
    if ({b3.host_gnt, b3.mem_addr} !== {1'b1, 6'h09}) begin
      nerrors++; $display("FAIL il_wr1: got gnt=%b addr=%h want 1 09", b3.host_gnt, b3.mem_addr);
    end
    tick();
    b3.host_req = 1'b0;
    tick();
    b3.dsp_req = 1'b1;  b3.dsp_we = 1'b0;  b3.dsp_addr = 6'h07;
    b3.host_req = 1'b1; b3.host_we = 1'b0; b3.host_addr = 6'h09;
    tick();
    smp();
    nchecks++;
    if ({b3.dsp_gnt, b3.host_gnt, b3.mem_we, b3.mem_addr} !== {3'b100, 6'h07}) begin
      nerrors++;
      $display("FAIL il_dsp_gnt: got gnt=%b%b we=%b addr=%h want 10 0 07", b3.dsp_gnt,
               b3.host_gnt, b3.mem_we, b3.mem_addr);
    end
    tick();
    b3.dsp_req = 1'b0;
    smp();
    nchecks++;
    if ({b3.dsp_gnt, b3.host_gnt, b3.mem_addr} !== {2'b01, 6'h09}) begin
      nerrors++;
      $display("FAIL il_host_gnt: got gnt=%b%b addr=%h want 01 09", b3.dsp_gnt, b3.host_gnt,
               b3.mem_addr);
    end
    tick();
    b3.host_req = 1'b0;
    smp();
    nchecks++;
    if ({b3.dsp_rvalid, b3.host_rvalid} !== 2'b00) begin
      nerrors++;
      $display("FAIL il_rv_early: got %b want %b", {b3.dsp_rvalid, b3.host_rvalid}, 2'b00);
    end
    tick();
    smp();
    nchecks++;
    if ({b3.dsp_rvalid, b3.host_rvalid, b3.dsp_rdata} !== {2'b10, 14'h1111}) begin
      nerrors++;
      $display("FAIL il_dsp_ret: got rv=%b%b data=%h want 10 1111", b3.dsp_rvalid,
               b3.host_rvalid, b3.dsp_rdata);
    end
    tick();
    smp();
    nchecks++;
    if ({b3.dsp_rvalid, b3.host_rvalid, b3.host_rdata} !== {2'b01, 14'h2222}) begin
      nerrors++;
      $display("FAIL il_host_ret: got rv=%b%b data=%h want 01 2222", b3.dsp_rvalid,
               b3.host_rvalid, b3.host_rdata);
    end
    tick();
    smp();
    nchecks++;
    if ({b3.dsp_rvalid, b3.host_rvalid} !== 2'b00) begin
      nerrors++;
      $display("FAIL il_rv_late: got %b want %b", {b3.dsp_rvalid, b3.host_rvalid}, 2'b00);
    end
  endtask

  task automatic test_reset_mid_burst();
    tick();
    b3.dsp_req = 1'b1; b3.dsp_we = 1'b0; b3.dsp_addr = 6'h07;
    tick();
    smp();
    nchecks++;
    if (b3.dsp_gnt !== 1'b1) begin
      nerrors++; $display("FAIL rst_pre_gnt0: got %b want %b", b3.dsp_gnt, 1'b1);
    end
    tick();
    smp();
    nchecks++;
    if (b3.dsp_gnt !== 1'b1) begin
      nerrors++; $display("FAIL rst_pre_gnt1: got %b want %b", b3.dsp_gnt, 1'b1);
    end
    #1;
    rst = 1'b1;
    #1;
    nchecks++;
    if ({b3.dsp_gnt, b3.mem_cs, b3.busy, b3.mem_addr} !== 9'b0) begin
      nerrors++;
      $display("FAIL rst_async: got gnt=%b cs=%b busy=%b addr=%h want 0 0 0 00", b3.dsp_gnt,
               b3.mem_cs, b3.busy, b3.mem_addr);
    end
    b3.dsp_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      smp();
      nchecks++;
      if ({b3.dsp_rvalid, b3.host_rvalid, b3.busy} !== 3'b000) begin
        nerrors++;
        $display("FAIL rst_no_rvalid[%0d]: got %b want %b", i,
                 {b3.dsp_rvalid, b3.host_rvalid, b3.busy}, 3'b000);
      end
      tick();
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_dsp_write();
    test_host_read();
    test_burst();
    test_owner_drop();
    test_interleaved();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
